result_misr_collector: RTL and testbench
========================================

Name: result_misr_collector

Overview:
- Downstream neighbour of the input shift-register/compressor wrapper used for FPGA timing and evaluation.
- Registers the compressor's parallel result bits every cycle and folds them into a multiple-input signature register (MISR).
- On request, serializes a snapshot of the signature through a valid/ready bit stream, so the wide result needs only a few pins.

Parameters:
- WIDTH, 20, number of compressor result bits (dst0..dstN-1, concatenated with dst0 at bit 0); also the MISR width.
- TAPS, 20'h90000, Fibonacci feedback mask (x^20+x^17+1, taps at bits 19 and 16).
- SEED, 20'h00000, MISR value after reset and after clear.
- CNT_W, 16, width of the sample counter.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream shift register.
- rst  input  1  synchronous, active-high reset.
- dst_in  input  WIDTH  compressor result bits, dst0 at bit 0.
- en  input  1  compress the registered sample this cycle.
- clear  input  1  reload MISR with SEED and zero the counter.
- dump  input  1  single-cycle pulse that snapshots the MISR and starts serial readout.
- sig_bit  output  1  serial signature bit, MSB first.
- sig_valid  output  1  sig_bit is valid.
- sig_ready  input  1  downstream accepts sig_bit.
- sig_last  output  1  current bit is the final (LSB) bit.
- busy  output  1  readout in progress.
- sample_count  output  CNT_W  number of compressed samples, wraps modulo 2^CNT_W.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - dst_q=0, misr=SEED, sample_count=0.
  - State IDLE, shadow=0, bit index=0.
  - sig_valid=0, sig_bit=0, sig_last=0, busy=0.
  - rst mid-readout aborts the readout immediately; no further bits are emitted.
- Input stage: dst_q <= dst_in every cycle, with no enable. There is a fixed 1-cycle latency from dst_in to the MISR.
- MISR update, when en=1 and clear=0:
  - fb = XOR-reduce(misr & TAPS)
  - misr <= {misr[WIDTH-2:0], fb} ^ dst_q
  - sample_count <= sample_count+1, wrapping at 2^CNT_W.
  - When en=0, misr and the counter hold.
- clear has priority over en: misr <= SEED and count <= 0. clear does not affect an active readout, because the shadow copy is independent.
- The MISR and counter keep running in both states. Readout never stalls compression.
- State machine (2 states):
  - IDLE: sig_valid=0, busy=0. If dump=1, then shadow <= misr, taking the value before the same-cycle update, and idx <= WIDTH-1, and the state moves to SHIFT.
  - SHIFT: sig_valid=1, busy=1, sig_bit=shadow[idx], sig_last=(idx==0).
    - On sig_valid&&sig_ready: if idx==0, go to IDLE; otherwise idx <= idx-1.
    - When sig_ready=0, sig_bit, sig_last and sig_valid are held stable.
  - dump in SHIFT is ignored, with no restart and no queueing.
  - dump in the same cycle the last bit is accepted is ignored. The next dump is honoured from IDLE, one cycle later at the earliest.
- Timing and throughput:
  - The first bit is valid in the cycle after dump.
  - With sig_ready held at 1, a readout takes exactly WIDTH cycles, and busy falls in the cycle after sig_last is accepted.
- All outputs are registered or decoded directly from state, shadow and idx. There is no combinational path from sig_ready to sig_valid.

Decomposition:
- Shared package holds:
  - Constants: WIDTH, TAPS and SEED defaults for each generated compressor size.
  - The 1-bit state enum (IDLE, SHIFT).
  - A function that computes the MISR next-state, for reuse by the bench model.
- One natural sub-module, misr_core: dst_q register, MISR, counter, clear and en handling.
- The top level adds the snapshot/serializer FSM.
- Expected RTL size is about 150-220 lines.

Test Plan:
- Reset then en=1 with dst_in=0 for 10 cycles -> misr stays 20'h00000, sample_count=10, sig_valid=0.
- dst_in=20'h00001 for one cycle, then 0, with en=1 throughout; dump asserted 4 cycles after the sample was compressed, sig_ready=1:
  - misr=20'h00010 at the snapshot.
  - 20 bits are emitted, with sig_bit=1 only on the 16th bit.
  - sig_last is set on the 20th bit; busy is high for 20 cycles.
- Same as the previous case, but sig_ready toggles 1,0,1,0 -> each bit is held while ready=0, the sequence is identical, and the readout takes 39 cycles.
- Wrap: a single 1 injected at bit 0 with zero input following -> after 16 more shifts misr=20'h10000, and the next cycle gives 20'h20001 (feedback from bit 16).
- dump during SHIFT and clear during SHIFT -> the serial stream is unchanged. After clear, misr=SEED and sample_count=0.
- rst asserted at bit 7 of a readout -> sig_valid=0 and busy=0 in the next cycle, misr=SEED, and a subsequent dump gives a full, correct 20-bit readout.
- CNT_W=4 build, 17 en cycles -> sample_count=1 (wrap).

Source files
------------

// File: rtl/result_misr_collector_pkg.sv
// result_misr_collector_pkg: shared constants, FSM state type and MISR next-state function.
package result_misr_collector_pkg;
  localparam int          DEF_WIDTH = 20;
  localparam logic [63:0] DEF_TAPS  = 64'h9_0000;
  localparam logic [63:0] DEF_SEED  = 64'h0;
  localparam int          DEF_CNT_W = 16;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic [63:0] default_taps(input int w);
    return w == 8 ? 64'hB8 : w == 16 ? 64'hB400 : w == 32 ? 64'h8020_0003 : DEF_TAPS;
  endfunction
  function automatic logic [63:0] misr_next(input logic [63:0] m, input logic [63:0] d,
                                            input logic [63:0] taps, input int w);
    logic [63:0] r;
    r = {m[62:0], ^(m & taps)} ^ d;
    return w >= 64 ? r : r & ((64'h1 << w) - 64'h1);
  endfunction
endpackage

// File: rtl/result_misr_collector_misr_core.sv
// result_misr_collector_misr_core: input register, MISR and sample counter with clear/en.
module result_misr_collector_misr_core
  import result_misr_collector_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int               CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_dst,
  input  logic             i_en,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_misr,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_dst_q;
  logic [WIDTH-1:0] r_misr;
  logic [WIDTH-1:0] w_misr_nx;
  logic [CNT_W-1:0] r_count;
  assign w_misr_nx = WIDTH'(misr_next(64'(r_misr), 64'(r_dst_q), 64'(TAPS), WIDTH));
  assign o_misr    = r_misr;
  assign o_count   = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dst_q <= '0;
      r_misr  <= SEED;
      r_count <= '0;
    end else begin
      r_dst_q <= i_dst;
      if (i_clear) begin
        r_misr  <= SEED;
        r_count <= '0;
      end else if (i_en) begin
        r_misr  <= w_misr_nx;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/result_misr_collector.sv
// result_misr_collector: compresses result bits into a MISR and serializes signature snapshots.
module result_misr_collector
  import result_misr_collector_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int               CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dst_in,
  input  logic             en,
  input  logic             clear,
  input  logic             dump,
  output logic             sig_bit,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic             sig_last,
  output logic             busy,
  output logic [CNT_W-1:0] sample_count
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shadow;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] w_misr;
  logic             w_acc;
  result_misr_collector_misr_core #(
    .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .CNT_W(CNT_W)
  ) u_core (
    .clk(clk), .rst(rst), .i_dst(dst_in), .i_en(en), .i_clear(clear),
    .o_misr(w_misr), .o_count(sample_count)
  );
  assign w_acc = (r_state == SHIFT) && sig_ready;
  // shadow decouples the readout from clear and ongoing compression
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && dump) begin
        r_shadow <= w_misr;
        r_idx    <= IW'(WIDTH - 1);
      end else if (w_acc && r_idx != '0) begin
        r_idx <= r_idx - IW'(1);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = dump ? SHIFT : IDLE;
    else w_next = (w_acc && r_idx == '0) ? IDLE : SHIFT;
  end
  always_comb begin
    sig_valid = r_state == SHIFT;
    busy      = r_state == SHIFT;
    sig_bit   = (r_state == SHIFT) && r_shadow[r_idx];
    sig_last  = (r_state == SHIFT) && r_idx == '0;
  end
endmodule

// File: tb/tb_result_misr_collector.sv
// tb_result_misr_collector: table, directed and random checks against a queue-based model.
module tb_result_misr_collector;
  localparam int W = 20;
  logic          clk = 0;
  logic          rst = 1, en = 0, clr = 0, dump = 0, rdy = 0;
  logic [W-1:0]  din = '0;
  logic          sig_bit, sig_valid, sig_last, busy;
  logic [15:0]   cnt;
  logic          sig_bit4, sig_valid4, sig_last4, busy4;
  logic [3:0]    cnt4;
  int            checks = 0, errors = 0;
  logic [W-1:0]  mm = '0, mdq = '0;
  int            mcnt = 0;
  logic          q[$];
  typedef struct {logic rst; logic en; logic [W-1:0] din; logic [15:0] cnt; logic valid;} vec_t;
  vec_t          tv[11];
  logic [W-1:0]  bits;
  int            cyc;

  result_misr_collector dut (
    .clk(clk), .rst(rst), .dst_in(din), .en(en), .clear(clr), .dump(dump),
    .sig_bit(sig_bit), .sig_valid(sig_valid), .sig_ready(rdy), .sig_last(sig_last),
    .busy(busy), .sample_count(cnt)
  );
  result_misr_collector #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .dst_in(din), .en(en), .clear(clr), .dump(dump),
    .sig_bit(sig_bit4), .sig_valid(sig_valid4), .sig_ready(rdy), .sig_last(sig_last4),
    .busy(busy4), .sample_count(cnt4)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mref(input logic [W-1:0] m, input logic [W-1:0] d);
    logic fb;
    fb = m[19] ^ m[16];
    return W'({m, fb}) ^ d;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      mdq = '0; mm = '0; mcnt = 0; q.delete();
    end else begin
      if (q.size() != 0) begin
        if (rdy) void'(q.pop_front());
      end else if (dump) begin
        for (int i = W - 1; i >= 0; i--) q.push_back(mm[i]);
      end
      if (clr) begin
        mm = '0; mcnt = 0;
      end else if (en) begin
        mm = mref(mm, mdq); mcnt = (mcnt + 1) & 16'hFFFF;
      end
      mdq = din;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("valid", sig_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("last", sig_last, q.size() == 1);
    chk("bit", sig_bit, q.size() != 0 ? q[0] : 1'b0);
    chk("count", cnt, mcnt);
    chk("count4", cnt4, mcnt & 15);
    chk("misr", dut.u_core.r_misr, mm);
  endtask

  task automatic inject_and_dump();
    en = 1; clr = 1; din = '0; step();
    clr = 0; din = 20'h00001; step();
    din = '0; step();
    repeat (4) step();
    dump = 1; step();
    dump = 0;
  endtask

  task automatic readout(input int pat, output logic [W-1:0] b, output int c);
    b = '0; c = 0;
    while (busy && c < 100) begin
      rdy = (pat == 0) ? 1'b1 : (c % 2 == 0);
      if (sig_valid && rdy) b = {b[W-2:0], sig_bit};
      c++;
      step();
    end
    if (c >= 100) chk("readout_timeout", c, 0);
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b0, '0, 16'd0, 1'b0};
    for (int i = 1; i <= 10; i++) tv[i] = '{1'b0, 1'b1, '0, 16'(i), 1'b0};
    for (int i = 0; i <= 10; i++) begin
      rst = tv[i].rst; en = tv[i].en; din = tv[i].din;
      step();
      chk("tv_cnt", cnt, tv[i].cnt);
      chk("tv_valid", sig_valid, tv[i].valid);
      chk("tv_misr", dut.u_core.r_misr, 20'h00000);
    end
    rdy = 1;
    inject_and_dump();
    chk("snap_misr", dut.r_shadow, 20'h00010);
    readout(0, bits, cyc);
    chk("ro_bits", bits, 20'h00010);
    chk("ro_cycles", cyc, 20);
    inject_and_dump();
    readout(1, bits, cyc);
    chk("ro_toggle_bits", bits, 20'h00010);
    chk("ro_toggle_cycles", cyc, 39);
    rdy = 1; clr = 1; step();
    clr = 0; din = 20'h00001; step();
    din = '0; step();
    repeat (16) step();
    chk("wrap_pre", dut.u_core.r_misr, 20'h10000);
    step();
    chk("wrap_fb", dut.u_core.r_misr, 20'h20001);
    inject_and_dump();
    bits = '0; cyc = 0;
    while (busy && cyc < 100) begin
      dump = (cyc == 3); clr = (cyc == 5);
      if (sig_valid) bits = {bits[W-2:0], sig_bit};
      cyc++;
      step();
      if (cyc == 6) begin
        chk("clr_misr", dut.u_core.r_misr, 20'h00000);
        chk("clr_cnt", cnt, 0);
      end
    end
    dump = 0; clr = 0;
    chk("shift_ignore_bits", bits, 20'h00010);
    chk("shift_ignore_cycles", cyc, 20);
    inject_and_dump();
    repeat (7) step();
    rst = 1; step();
    rst = 0;
    chk("rst_valid", sig_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_misr", dut.u_core.r_misr, 20'h00000);
    inject_and_dump();
    readout(0, bits, cyc);
    chk("post_rst_bits", bits, 20'h00010);
    chk("post_rst_cycles", cyc, 20);
    rst = 1; step();
    rst = 0; en = 1;
    repeat (17) step();
    chk("cnt4_wrap", cnt4, 1);
    chk("cnt16", cnt, 17);
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(199) == 0);
      clr  = ($urandom_range(49) == 0);
      dump = ($urandom_range(19) == 0);
      rdy  = $urandom_range(1);
      en   = ($urandom_range(3) != 0);
      din  = W'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
